vector_mem_arbiter: RTL and testbench

Two-port request/response controller in front of the 512 x 32-bit vector memory. It arbitrates round-robin between two vector requesters (port 0, port 1), each issuing 16-word (512-bit) loads or stores. It sequences the memory's enable, address and data pins through a fixed three-phase transaction and returns read data or write acknowledgements with a fixed latency. It rejects out-of-range accesses before they reach the array.

---
 rtl/vector_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_vector_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_arbiter.sv
// Two-port round-robin front end for the 512 x 32-bit vector memory.
// Each accepted request runs IDLE -> ACCESS -> RESP. The memory pins are
// driven during ACCESS. The owning port gets a one-cycle response in RESP.
// Requests whose 16-word window would run past the end of the array are
// flagged with err and never reach the memory enables.

// Per-port response register: valid/err pulse and held load data.
module vma_rsp_port #(
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fire,      // this port owns the ACCESS cycle
    input  logic              load,      // owning transaction is a load
    input  logic              err,       // owning transaction is out of range
    input  logic [DATA_W-1:0] mem_out,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata
);

    // Pulse valid in RESP. Loads refresh rdata; stores leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= fire;
            rsp_err   <= fire & err;
            if (fire & load)
                rsp_rdata <= err ? '0 : mem_out;
        end
    end

endmodule

module vector_mem_arbiter #(
    parameter int DEPTH  = 512,
    parameter int VLEN   = 16,
    parameter int ADDR_W = 9,
    parameter int DATA_W = VLEN * 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic              rsp0_err,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int NUM_PORTS = 2;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - VLEN);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Request fields after the port mux.
    typedef struct packed {
        logic              port;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } req_t;

    // Transaction state kept for the ACCESS/RESP phases.
    typedef struct packed {
        logic port;
        logic write;
        logic err;
    } txn_t;

    state_t              state;
    logic                last_grant;
    txn_t                cur;
    req_t                sel;
    logic [DATA_W-1:0]   sel_wdata;
    logic                accept;

    logic [NUM_PORTS-1:0]             fire;
    logic [NUM_PORTS-1:0]             rsp_valid_a;
    logic [NUM_PORTS-1:0]             rsp_err_a;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_rdata_a;

    // Round-robin grant. A lone valid always wins. On a tie, the port that
    // was not granted last time wins.
    always_comb begin
        sel       = '0;
        sel_wdata = '0;
        if (req0_valid & req1_valid)
            sel.port = ~last_grant;
        else
            sel.port = req1_valid;
        sel.write = sel.port ? req1_write : req0_write;
        sel.addr  = sel.port ? req1_addr  : req0_addr;
        sel.err   = (sel.addr > MAX_ADDR);
        sel_wdata = sel.port ? req1_wdata : req0_wdata;
    end

    assign accept     = (state == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = accept & ~sel.port;
    assign req1_ready = accept &  sel.port;

    // Transaction FSM. Memory pins are loaded on accept so they are valid for
    // the whole ACCESS cycle. They are cleared again when leaving ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            last_grant        <= 1'b1;
            cur               <= '0;
            mem_read_enable   <= 1'b0;
            mem_write_enable  <= 1'b0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_data          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ACCESS;
                        last_grant <= sel.port;
                        cur.port   <= sel.port;
                        cur.write  <= sel.write;
                        cur.err    <= sel.err;
                        // Out-of-range requests leave the memory pins untouched.
                        if (!sel.err) begin
                            mem_read_enable   <= ~sel.write;
                            mem_write_enable  <=  sel.write;
                            mem_read_address  <= sel.addr;
                            mem_write_address <= sel.addr;
                            mem_data          <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state            <= RESP;
                    mem_read_enable  <= 1'b0;
                    mem_write_enable <= 1'b0;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One response register set per port. The port that owns ACCESS fires.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign fire[i] = (state == ACCESS) & (cur.port == 1'(i));

        vma_rsp_port #(.DATA_W(DATA_W)) u_rsp (
            .clk       (clk),
            .reset     (reset),
            .fire      (fire[i]),
            .load      (~cur.write),
            .err       (cur.err),
            .mem_out   (mem_out),
            .rsp_valid (rsp_valid_a[i]),
            .rsp_err   (rsp_err_a[i]),
            .rsp_rdata (rsp_rdata_a[i])
        );
    end

    assign rsp0_valid = rsp_valid_a[0];
    assign rsp0_err   = rsp_err_a[0];
    assign rsp0_rdata = rsp_rdata_a[0];
    assign rsp1_valid = rsp_valid_a[1];
    assign rsp1_err   = rsp_err_a[1];
    assign rsp1_rdata = rsp_rdata_a[1];

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Scoreboard bench for vector_mem_arbiter: directed scenarios followed by
// random two-port traffic, with a memory model behind the DUT.
module tb_vector_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [8:0]   req0_addr = 0, req1_addr = 0;
    logic [511:0] req0_wdata = 0, req1_wdata = 0;
    logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [511:0] rsp0_rdata, rsp1_rdata;
    logic         mem_read_enable, mem_write_enable;
    logic [8:0]   mem_read_address, mem_write_address;
    logic [511:0] mem_data, mem_out;

    int n_vec = 0;
    int n_err = 0;

    vector_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_rdata(rsp1_rdata),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_data(mem_data), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_9E37;
    endfunction

    // Memory model behind the DUT: combinational read, write on the clock edge.
    logic [31:0] mem [512];
    bit mem_init = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
            mem_init <= 1;
        end else if (mem_write_enable) begin
            for (int k = 0; k < 16; k++)
                mem[(int'(mem_write_address) + k) % 512] <= mem_data[32*k +: 32];
        end
    end
    always_comb begin
        mem_out = '0;
        for (int k = 0; k < 16; k++)
            mem_out[32*k +: 32] = mem[(int'(mem_read_address) + k) % 512];
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard monitor ----------------
    typedef struct {
        bit           write;
        bit           err;
        logic [8:0]   addr;
        logic [511:0] wdata;
        logic [511:0] rdata;
        int           due;
    } exp_t;

    exp_t         q0[$], q1[$];
    logic [31:0]  ref_mem [512];
    logic [511:0] shown [2];

    function automatic logic [511:0] ref_win(input logic [8:0] a);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = ref_mem[(int'(a) + k) % 512];
        return r;
    endfunction

    initial begin : monitor
        int cyc, busy_until, lg, acc_cyc;
        bit acc_re, acc_we;
        logic [8:0] acc_addr;
        logic [511:0] acc_data;
        bit v[2], rdy[2], rv[2], re[2], pv[2], pr[2];
        logic [8:0] a[2], pa[2];
        bit w[2], pw[2];
        logic [511:0] d[2], rd[2], pd[2];
        exp_t e;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
        cyc = 0; busy_until = 0; lg = 1; acc_cyc = -10;
        acc_re = 0; acc_we = 0; acc_addr = 0; acc_data = 0;
        pv[0] = 0; pv[1] = 0; pr[0] = 0; pr[1] = 0;
        shown[0] = '0; shown[1] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            v[0] = req0_valid; v[1] = req1_valid; rdy[0] = req0_ready; rdy[1] = req1_ready;
            a[0] = req0_addr; a[1] = req1_addr; w[0] = req0_write; w[1] = req1_write;
            d[0] = req0_wdata; d[1] = req1_wdata;
            rv[0] = rsp0_valid; rv[1] = rsp1_valid; re[0] = rsp0_err; re[1] = rsp1_err;
            rd[0] = rsp0_rdata; rd[1] = rsp1_rdata;
            if (!reset) begin
                chk("reset_ctrl", 512'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
                     rsp1_err, mem_read_enable, mem_write_enable}), 512'(0));
                chk("reset_addr", 512'({mem_read_address, mem_write_address}), 512'(0));
                chk("reset_mem_data", mem_data, '0);
                chk("reset_rdata0", rsp0_rdata, '0);
                chk("reset_rdata1", rsp1_rdata, '0);
                q0.delete(); q1.delete();
                busy_until = 0; lg = 1; acc_cyc = -10;
                shown[0] = '0; shown[1] = '0;
                pv[0] = 0; pv[1] = 0;
                continue;
            end
            // requester must hold its request stable while waiting
            for (int p = 0; p < 2; p++) begin
                if (pv[p] && !pr[p] && v[p])
                    assert (a[p] == pa[p] && w[p] == pw[p] && d[p] == pd[p])
                        else $error("requester %0d changed request while waiting", p);
                pv[p] = v[p]; pr[p] = rdy[p]; pa[p] = a[p]; pw[p] = w[p]; pd[p] = d[p];
            end
            // responses: pop and compare whenever the DUT presents one
            for (int p = 0; p < 2; p++) begin
                bit have;
                have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (rv[p]) begin
                    if (!have) begin
                        n_vec++; n_err++;
                        $display("FAIL spurious_rsp port %0d at cycle %0d: got valid want none", p, cyc);
                    end else begin
                        e = (p == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rsp%0d_cycle", p), 512'(cyc), 512'(e.due));
                        chk($sformatf("rsp%0d_err", p), 512'(re[p]), 512'(e.err));
                        if (!e.write) shown[p] = e.rdata;
                        if (e.write && !e.err)
                            for (int k = 0; k < 16; k++)
                                ref_mem[(int'(e.addr) + k) % 512] = e.wdata[32*k +: 32];
                        chk($sformatf("rsp%0d_rdata", p), rd[p], shown[p]);
                    end
                end else begin
                    if (have) begin
                        e = (p == 0) ? q0[0] : q1[0];
                        if (e.due <= cyc) begin
                            n_vec++; n_err++;
                            $display("FAIL missing_rsp port %0d: got none by cycle %0d want one at %0d",
                                     p, cyc, e.due);
                            if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        end
                    end
                    if (re[p]) begin
                        n_vec++; n_err++;
                        $display("FAIL rsp%0d_err_without_valid: got 1 want 0", p);
                    end
                    if (rd[p] !== shown[p]) chk($sformatf("rsp%0d_rdata_held", p), rd[p], shown[p]);
                end
            end
            // memory pins: enables only in the access cycle of a legal request
            if (acc_cyc == cyc) begin
                chk("mem_enables", 512'({mem_read_enable, mem_write_enable}), 512'({acc_re, acc_we}));
                if (acc_re || acc_we) begin
                    chk("mem_addrs", 512'({mem_read_address, mem_write_address}),
                        512'({acc_addr, acc_addr}));
                    if (acc_we) chk("mem_data", mem_data, acc_data);
                end
            end else if (mem_read_enable || mem_write_enable) begin
                chk("mem_enables_idle", 512'({mem_read_enable, mem_write_enable}), 512'(0));
            end
            // grant: idle for 3 cycles after an accept, round-robin on ties
            begin
                int win;
                bit idle;
                idle = (cyc >= busy_until);
                win = (v[0] && v[1]) ? 1 - lg : (v[1] ? 1 : 0);
                if (idle && (v[0] || v[1]))
                    chk("ready", 512'({rdy[1], rdy[0]}), 512'(win == 1 ? 2'b10 : 2'b01));
                else if (rdy[0] || rdy[1])
                    chk("ready_busy", 512'({rdy[1], rdy[0]}), 512'(0));
                if (idle && (v[0] || v[1])) begin
                    lg = win;
                    busy_until = cyc + 3;
                    e.write = w[win];
                    e.addr  = a[win];
                    e.wdata = d[win];
                    e.err   = (int'(a[win]) + 16 > 512);
                    e.rdata = e.err ? '0 : ref_win(a[win]);
                    e.due   = cyc + 2;
                    if (win == 0) q0.push_back(e); else q1.push_back(e);
                    acc_cyc  = cyc + 1;
                    acc_re   = !e.err && !e.write;
                    acc_we   = !e.err && e.write;
                    acc_addr = a[win];
                    acc_data = d[win];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input int p, input bit vl, input bit w, input logic [8:0] a,
                         input logic [511:0] d);
        if (p == 0) begin req0_valid = vl; req0_write = w; req0_addr = a; req0_wdata = d; end
        else        begin req1_valid = vl; req1_write = w; req1_addr = a; req1_wdata = d; end
    endtask

    // Raise a request and hold it until accepted (called just after a rising edge).
    task automatic do_req(input int p, input bit w, input logic [8:0] a, input logic [511:0] d);
        int n;
        bit ok;
        n = 0;
        drive(p, 1, w, a, d);
        do begin
            @(negedge clk);
            n++;
            ok = (p == 0) ? req0_ready : req1_ready;
        end while (!ok && n < 60);
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout port %0d: got no ready in %0d cycles want ready", p, n);
        end
        @(posedge clk); #1;
        if (p == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 0;
        repeat (cycles) @(posedge clk);
        #1 reset = 1;
    endtask

    initial begin
        logic [511:0] wd;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;

        // store then load, port 0
        for (int k = 0; k < 16; k++) wd[32*k +: 32] = 32'hA500_0000 + 32'(k);
        do_req(0, 1, 9'h010, wd);
        do_req(0, 0, 9'h010, '0);
        repeat (4) @(posedge clk);
        #1 chk("store_load_rdata", rsp0_rdata, wd);

        // both ports loading continuously after reset
        do_reset(2);
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 3; i++) do_req(0, 0, 9'($urandom_range(0, 496)), '0);
            for (int i = 0; i < 3; i++) do_req(1, 0, 9'($urandom_range(0, 496)), '0);
        join
        repeat (3) @(posedge clk); #1;

        // boundary addresses
        do_req(0, 0, 9'd496, '0);
        do_req(1, 1, 9'd497, rnd512());
        do_req(0, 0, 9'd511, '0);
        do_req(0, 0, 9'd496, '0);
        repeat (3) @(posedge clk); #1;

        // reset during the ACCESS cycle of a store
        do_req(0, 1, 9'h080, rnd512());
        #2 reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        fork
            do_req(0, 0, 9'h080, '0);
            do_req(1, 0, 9'h090, '0);
        join

        // held read data across a store and the other port's load
        do_req(1, 0, 9'h020, '0);
        do_req(1, 1, 9'h030, rnd512());
        do_req(0, 0, 9'h040, '0);
        repeat (3) @(posedge clk); #1;

        // random two-port traffic
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 do_req(0, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? 9'($urandom_range(490, 511))
                                                      : 9'($urandom_range(0, 496)), rnd512());
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 do_req(1, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? 9'($urandom_range(490, 511))
                                                      : 9'($urandom_range(0, 496)), rnd512());
            end
        join
        repeat (6) @(posedge clk); #1;

        chk("queues_drained", 512'(q0.size() + q1.size()), 512'(0));
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("memory_contents", 512'(bad), 512'(0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
